// File: rtl/dircc_counter_receive_handler_pkg.sv
// dircc_counter_receive_handler_pkg
// Shared types and constants for the counter application receive handler.
//   packet_data_t   : raw inbound packet word, tick value in bits [15:0]
//   device_state_t  : device state record read from and written back to state memory
//   dev_state_t     : counter view of user_state[31:0] as {rts, count}
//   tick_msg_t      : counter view of an inbound packet
//   recv_state_t    : receive handler FSM encoding
package dircc_counter_receive_handler_pkg;

  localparam int PACKET_WIDTH = 32;

  typedef logic [PACKET_WIDTH-1:0] packet_data_t;

  typedef struct packed {
    logic [31:0] dircc_state;
    logic [31:0] dircc_state_extra;
    logic [63:0] user_state;
  } device_state_t;

  localparam logic [31:0] DIRCC_STATE_DONE    = 32'h0000_0001;
  localparam logic [31:0] DIRCC_STATE_STOPPED = 32'h0000_0002;

  localparam logic [15:0] COUNTER_MAX_COUNT_DEFAULT = 16'd100;

  typedef struct packed {
    logic [15:0] rts;
    logic [15:0] count;
  } dev_state_t;

  typedef struct packed {
    logic [15:0] reserved;
    logic [15:0] tick;
  } tick_msg_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_UPDATE,
    ST_WRITE
  } recv_state_t;

  // rts must never wrap back to zero, or pending replies would be forgotten
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/dircc_counter_receive_handler_update.sv
// dircc_counter_receive_handler_update
// Purely combinational update step of the counter receive handler: decides
// whether an incoming tick is dropped and computes the new device state.
// Ports:
//   tick       in   16-bit tick value from the packet
//   cur_state  in   device state as read from state memory
//   drop       out  1 = discard packet, no write-back
//   next_state out  device state to write back when drop=0
module dircc_counter_receive_handler_update
  import dircc_counter_receive_handler_pkg::*;
#(
  parameter logic [15:0] MAX_COUNT = COUNTER_MAX_COUNT_DEFAULT
) (
  input  logic [15:0]   tick,
  input  device_state_t cur_state,
  output logic          drop,
  output device_state_t next_state
);

  dev_state_t cur_dev;
  dev_state_t next_dev;

  // Stale ticks (older than the stored count) and stopped devices are ignored.
  // count = tick+1 is allowed to wrap at 16 bits; everything outside
  // user_state[31:0] and the DONE bit is passed through untouched.
  always_comb begin
    cur_dev        = dev_state_t'(cur_state.user_state[31:0]);
    drop           = ((cur_state.dircc_state & DIRCC_STATE_STOPPED) != '0) ||
                     (tick < cur_dev.count);
    next_dev.count = tick + 16'd1;
    next_dev.rts   = sat_inc16(cur_dev.rts);
    next_state     = cur_state;
    next_state.user_state[31:0] = next_dev;
    if (next_dev.count >= MAX_COUNT) begin
      next_state.dircc_state = cur_state.dircc_state | DIRCC_STATE_DONE;
    end
  end

endmodule

// File: rtl/dircc_counter_receive_handler.sv
// dircc_counter_receive_handler
// Receive side of the counter application: accepts one tick packet at a time,
// reads the addressed device state, applies the counter update and writes the
// result back, scheduling a reply by bumping the device's rts count.
// Ports:
//   clk, reset                        clock, asynchronous active-high reset
//   address, packet_in(_valid/_ready) inbound packet and its target state address
//   state_address, state_read_req     state memory read request
//   read_state(_valid)                state memory read response
//   write_state(_valid/_ready)        state memory write request
//   rx_count, drop_count              packet statistics, only when the macro
//                                     DIRCC_COUNTER_RECV_STATS_EN is defined
module dircc_counter_receive_handler
  import dircc_counter_receive_handler_pkg::*;
#(
  parameter int          ADDRESS_MEM_WIDTH = 32,
  parameter              NODE_TYPE         = "default",
  parameter int          DEVICE_ID         = 0,
  parameter logic [15:0] MAX_COUNT         = COUNTER_MAX_COUNT_DEFAULT
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [ADDRESS_MEM_WIDTH-1:0] address,
  input  packet_data_t                 packet_in,
  input  logic                         packet_in_valid,
  output logic                         packet_in_ready,
  output logic [ADDRESS_MEM_WIDTH-1:0] state_address,
  output logic                         state_read_req,
  input  device_state_t                read_state,
  input  logic                         read_state_valid,
  output device_state_t                write_state,
  output logic                         write_state_valid,
  input  logic                         write_state_ready
`ifdef DIRCC_COUNTER_RECV_STATS_EN
  ,
  output logic [31:0]                  rx_count,
  output logic [31:0]                  drop_count
`endif
);

  recv_state_t   state;
  recv_state_t   state_next;
  tick_msg_t     msg;
  logic [15:0]   tick_q;
  device_state_t read_q;
  device_state_t update_result;
  logic          drop;
  logic          accept;

  // Informational parameters and reserved packet bits are intentionally not
  // part of the datapath.
  logic unused_ok;
  assign unused_ok = ^{msg.reserved, NODE_TYPE, DEVICE_ID};

  assign msg    = tick_msg_t'(packet_in);
  assign accept = (state == ST_IDLE) && packet_in_valid;

  dircc_counter_receive_handler_update #(
    .MAX_COUNT (MAX_COUNT)
  ) u_update (
    .tick       (tick_q),
    .cur_state  (read_q),
    .drop       (drop),
    .next_state (update_result)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:   if (packet_in_valid) state_next = ST_READ;
      ST_READ:   if (read_state_valid) state_next = ST_UPDATE;
      ST_UPDATE: state_next = drop ? ST_IDLE : ST_WRITE;
      ST_WRITE:  if (write_state_ready) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Ready is masked by reset so the upstream never sees a handshake while
  // the handler is held in reset.
  always_comb begin
    packet_in_ready   = (state == ST_IDLE) && !reset;
    state_read_req    = (state == ST_READ);
    write_state_valid = (state == ST_WRITE);
  end

  // write_state is only loaded in UPDATE, so it stays stable for the whole
  // WRITE phase regardless of how long the memory stalls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_q        <= '0;
      state_address <= '0;
      read_q        <= '0;
      write_state   <= '0;
    end else begin
      if (accept) begin
        tick_q        <= msg.tick;
        state_address <= address;
      end
      if ((state == ST_READ) && read_state_valid) begin
        read_q <= read_state;
      end
      if ((state == ST_UPDATE) && !drop) begin
        write_state <= update_result;
      end
    end
  end

`ifdef DIRCC_COUNTER_RECV_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_count   <= '0;
      drop_count <= '0;
    end else begin
      if (accept) begin
        rx_count <= rx_count + 32'd1;
      end
      if ((state == ST_UPDATE) && drop) begin
        drop_count <= drop_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dircc_counter_receive_handler.sv
// tb_dircc_counter_receive_handler
// Self-checking bench for dircc_counter_receive_handler. The bench plays the
// role of the inbound router and of the device state memory; expected
// write-backs are queued when a packet is driven and compared when the DUT
// presents them.
module tb_dircc_counter_receive_handler;
  import dircc_counter_receive_handler_pkg::*;

  logic          clk = 1'b0;
  logic          reset;
  logic [31:0]   address;
  packet_data_t  packet_in;
  logic          packet_in_valid;
  logic          packet_in_ready;
  logic [31:0]   state_address;
  logic          state_read_req;
  device_state_t read_state;
  logic          read_state_valid;
  device_state_t write_state;
  logic          write_state_valid;
  logic          write_state_ready;
`ifdef DIRCC_COUNTER_RECV_STATS_EN
  logic [31:0]   rx_count;
  logic [31:0]   drop_count;
`endif

  dircc_counter_receive_handler #(
    .ADDRESS_MEM_WIDTH (32),
    .MAX_COUNT         (16'd100)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .address           (address),
    .packet_in         (packet_in),
    .packet_in_valid   (packet_in_valid),
    .packet_in_ready   (packet_in_ready),
    .state_address     (state_address),
    .state_read_req    (state_read_req),
    .read_state        (read_state),
    .read_state_valid  (read_state_valid),
    .write_state       (write_state),
    .write_state_valid (write_state_valid),
    .write_state_ready (write_state_ready)
`ifdef DIRCC_COUNTER_RECV_STATS_EN
    ,
    .rx_count          (rx_count),
    .drop_count        (drop_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cycle = 0;
  int last_accept = -100;
  int rx_expected = 0;
  int drop_expected = 0;
  device_state_t exp_q[$];

  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string tag, input logic [127:0] actual,
                             input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // Reference behaviour: dircc_state bit0 = DONE, bit1 = STOPPED,
  // user_state[15:0] = count, user_state[31:16] = rts, MAX_COUNT = 100.
  function automatic void modelUpdate(input logic [15:0] tick, input device_state_t s,
                                      output logic drop, output device_state_t r);
    logic [15:0] cnt, rts, ncnt, nrts;
    cnt  = s.user_state[15:0];
    rts  = s.user_state[31:16];
    r    = s;
    drop = s.dircc_state[1] || (tick < cnt);
    ncnt = tick + 16'd1;
    nrts = (rts == 16'hFFFF) ? 16'hFFFF : rts + 16'd1;
    r.user_state[31:0] = {nrts, ncnt};
    if (ncnt >= 16'd100) r.dircc_state[0] = 1'b1;
  endfunction

  function automatic device_state_t makeState(input logic [31:0] ds, input logic [15:0] rts,
                                              input logic [15:0] cnt);
    device_state_t s;
    s.dircc_state       = ds;
    s.dircc_state_extra = $urandom;
    s.user_state        = {32'($urandom), rts, cnt};
    return s;
  endfunction

  task automatic checkStats();
`ifdef DIRCC_COUNTER_RECV_STATS_EN
    checkOutput("rx_count", rx_count, rx_expected);
    checkOutput("drop_count", drop_count, drop_expected);
`endif
  endtask

  // Drives one packet and answers the read/write requests with the given
  // delays. Optionally asserts reset while the write is pending.
  task automatic applyStimulus(input logic [31:0] addr, input logic [15:0] tick,
                               input device_state_t mem, input int rd_delay,
                               input int wr_delay, input bit check_spacing,
                               input bit reset_in_write);
    logic drop;
    device_state_t exp;
    int n;
    modelUpdate(tick, mem, drop, exp);

    n = 0;
    while (!packet_in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!packet_in_ready) begin
      checkOutput("ready_timeout", 0, 1);
      return;
    end

    address         = addr;
    packet_in       = {16'($urandom), tick};
    packet_in_valid = 1'b1;
    @(negedge clk);
    packet_in_valid = 1'b0;
    address         = $urandom;
    rx_expected++;
    if (check_spacing) checkOutput("accept_spacing", cycle - last_accept, 4);
    last_accept = cycle;
    if (!drop) exp_q.push_back(exp);

    checkOutput("read_req", state_read_req, 1);
    checkOutput("state_address", state_address, addr);
    checkOutput("ready_busy", packet_in_ready, 0);
    for (int i = 0; i < rd_delay; i++) begin
      @(negedge clk);
      checkOutput("read_req_held", state_read_req, 1);
    end
    read_state       = mem;
    read_state_valid = 1'b1;
    @(negedge clk);
    read_state_valid = 1'b0;
    read_state       = makeState($urandom, 16'($urandom), 16'($urandom));
    checkOutput("update_no_req", state_read_req, 0);
    checkOutput("update_no_wvalid", write_state_valid, 0);
    @(negedge clk);

    if (drop) begin
      drop_expected++;
      checkOutput("drop_no_write", write_state_valid, 0);
      checkOutput("drop_ready", packet_in_ready, 1);
      checkStats();
      return;
    end

    checkOutput("write_valid", write_state_valid, 1);
    if (reset_in_write) begin
      reset = 1'b1;
      #1;
      checkOutput("rst_wvalid", write_state_valid, 0);
      checkOutput("rst_ready", packet_in_ready, 0);
      checkOutput("rst_wstate", write_state, 0);
      checkOutput("rst_addr", state_address, 0);
      void'(exp_q.pop_front());
      rx_expected   = 0;
      drop_expected = 0;
      checkStats();
      @(negedge clk);
      reset = 1'b0;
      #1;
      checkOutput("post_rst_ready", packet_in_ready, 1);
      checkOutput("post_rst_wvalid", write_state_valid, 0);
      return;
    end

    for (int i = 0; i < wr_delay; i++) begin
      checkOutput("write_stable", write_state, exp_q[0]);
      @(negedge clk);
      checkOutput("write_valid_held", write_state_valid, 1);
    end
    write_state_ready = 1'b1;
    if (exp_q.size() == 0) checkOutput("scoreboard_empty", 0, 1);
    else checkOutput("write_data", write_state, exp_q.pop_front());
    @(negedge clk);
    write_state_ready = 1'b0;
    checkOutput("write_done", write_state_valid, 0);
    checkOutput("ready_after_write", packet_in_ready, 1);
    checkStats();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset             = 1'b1;
    address           = '0;
    packet_in         = '0;
    packet_in_valid   = 1'b0;
    read_state        = '0;
    read_state_valid  = 1'b0;
    write_state_ready = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_ready", packet_in_ready, 0);
    checkOutput("reset_read_req", state_read_req, 0);
    checkOutput("reset_wvalid", write_state_valid, 0);
    checkOutput("reset_wstate", write_state, 0);
    checkOutput("reset_addr", state_address, 0);
    checkStats();
    reset = 1'b0;
    #1;
    checkOutput("idle_ready", packet_in_ready, 1);
    @(negedge clk);

    $display("[TB] basic update and back-to-back spacing");
    applyStimulus(32'h0000_0100, 16'd5, makeState(32'h0, 16'd0, 16'd5), 0, 0, 0, 0);
    applyStimulus(32'h0000_0104, 16'd10, makeState(32'h0, 16'd7, 16'd6), 0, 0, 1, 0);

    $display("[TB] stale tick dropped");
    applyStimulus(32'h0000_0200, 16'd3, makeState(32'h0, 16'd0, 16'd5), 0, 0, 0, 0);

    $display("[TB] reaching MAX_COUNT sets DONE");
    applyStimulus(32'h0000_0300, 16'd99, makeState(32'h0, 16'd4, 16'd99), 0, 0, 0, 0);

    $display("[TB] rts saturation");
    applyStimulus(32'h0000_0400, 16'd20, makeState(32'h0, 16'hFFFF, 16'd10), 0, 0, 0, 0);

    $display("[TB] stopped device dropped with slow read");
    applyStimulus(32'h0000_0500, 16'd50, makeState(DIRCC_STATE_STOPPED, 16'd1, 16'd2), 5, 0, 0, 0);

    $display("[TB] slow read and slow write");
    applyStimulus(32'h0000_0600, 16'd40, makeState(32'h0, 16'd3, 16'd30), 5, 3, 0, 0);

    $display("[TB] tick wrap");
    applyStimulus(32'h0000_0700, 16'hFFFF, makeState(32'h0, 16'd9, 16'hFFF0), 0, 1, 0, 0);

    $display("[TB] reset during write");
    applyStimulus(32'h0000_0800, 16'd20, makeState(32'h0, 16'd2, 16'd10), 0, 0, 0, 1);
    applyStimulus(32'h0000_0804, 16'd21, makeState(32'h0, 16'd2, 16'd10), 0, 0, 0, 0);

    $display("[TB] random packets");
    for (int k = 0; k < 8; k++) begin
      logic [15:0] cnt, tk;
      cnt = 16'($urandom_range(0, 120));
      tk  = 16'($urandom_range(0, 120));
      applyStimulus($urandom, tk,
                    makeState({30'd0, 2'($urandom_range(0, 3))}, 16'($urandom), cnt),
                    $urandom_range(0, 3), $urandom_range(0, 3), 0, 0);
    end

    checkOutput("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
